// File: rtl/multicycle_alu.sv
// Registered ALU with start/busy/done handshake. Single-cycle ops complete at the
// capture edge; MUL (shift-add) and DIVU (restoring) iterate one bit per cycle.
module multicycle_alu #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [3:0]       FunSel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             WF,
   output logic [WIDTH-1:0] ALUOut,
   output logic [WIDTH-1:0] Hi,
   output logic [3:0]       FlagsOut,
   output logic             Busy,
   output logic             Done
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_A    = 4'b0000;
   localparam logic [3:0] OP_NOT  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_ADC  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NAND = 4'b1000;
   localparam logic [3:0] OP_LSL  = 4'b1001;
   localparam logic [3:0] OP_LSR  = 4'b1010;
   localparam logic [3:0] OP_ASR  = 4'b1011;
   localparam logic [3:0] OP_CSL  = 4'b1100;
   localparam logic [3:0] OP_CSR  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1110;
   localparam logic [3:0] OP_DIVU = 4'b1111;

   typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             wf_q, wf_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] alu_q, alu_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [3:0]       flags_q, flags_d;
   logic             done_q, done_d;

   // Single-cycle result path, driven straight from the inputs sampled with Start
   logic [WIDTH-1:0] sc_res, sc_hi;
   logic             sc_c, sc_o;
   logic [WIDTH:0]   sum;
   logic             cin;

   assign cin = flags_q[2];

   always_comb begin
      sc_res = A;
      sc_hi  = '0;
      sc_c   = flags_q[2];
      sc_o   = flags_q[0];
      sum    = '0;
      case (FunSel)
         OP_A:    sc_res = A;
         OP_NOT:  sc_res = ~A;
         OP_ADD, OP_ADC: begin
            sum    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (FunSel == OP_ADC) & cin};
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_o   = (A[WIDTH-1] == B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            sum    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
            sc_res = sum[WIDTH-1:0];
            sc_c   = ~sum[WIDTH];
            sc_o   = (A[WIDTH-1] != B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  sc_res = A & B;
         OP_OR:   sc_res = A | B;
         OP_XOR:  sc_res = A ^ B;
         OP_NAND: sc_res = ~(A & B);
         OP_LSL: begin sc_res = {A[WIDTH-2:0], 1'b0};       sc_c = A[WIDTH-1]; end
         OP_LSR: begin sc_res = {1'b0, A[WIDTH-1:1]};       sc_c = A[0];       end
         OP_ASR: begin sc_res = {A[WIDTH-1], A[WIDTH-1:1]}; sc_c = A[0];       end
         OP_CSL: begin sc_res = {A[WIDTH-2:0], cin};        sc_c = A[WIDTH-1]; end
         OP_CSR: begin sc_res = {cin, A[WIDTH-1:1]};        sc_c = A[0];       end
         OP_DIVU: begin
            // only reaches this path with B == 0
            sc_res = '1;
            sc_hi  = A;
            sc_c   = 1'b0;
            sc_o   = 1'b1;
         end
         default: sc_res = A;
      endcase
   end

   // One iteration step of either algorithm
   logic [WIDTH:0]   mul_add, div_rs;
   logic [WIDTH:0]   step_hi;
   logic [WIDTH-1:0] step_lo;

   always_comb begin
      mul_add = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      div_rs  = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
      if (is_div_q) begin
         if (div_rs >= {1'b0, opnd_q}) begin
            step_hi = div_rs - {1'b0, opnd_q};
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_rs;
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = {1'b0, mul_add[WIDTH:1]};
         step_lo = {mul_add[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   logic [3:0] it_flags;
   always_comb begin
      if (is_div_q)
         it_flags = {acc_lo_q == '0, 1'b0, acc_lo_q[WIDTH-1], 1'b0};
      else
         it_flags = {({acc_hi_q[WIDTH-1:0], acc_lo_q} == '0), acc_hi_q[WIDTH-1:0] != '0,
                     acc_lo_q[WIDTH-1], acc_hi_q[WIDTH-1:0] != '0};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      wf_d     = wf_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      alu_d    = alu_q;
      hi_d     = hi_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               if (FunSel == OP_MUL || (FunSel == OP_DIVU && B != '0)) begin
                  state_d  = ITER;
                  cnt_d    = CW'(WIDTH);
                  is_div_d = (FunSel == OP_DIVU);
                  wf_d     = WF;
                  // MUL shifts the multiplier B through acc_lo; DIVU shifts the dividend A
                  opnd_d   = (FunSel == OP_DIVU) ? B : A;
                  acc_lo_d = (FunSel == OP_DIVU) ? A : B;
                  acc_hi_d = '0;
               end else begin
                  alu_d  = sc_res;
                  hi_d   = sc_hi;
                  done_d = 1'b1;
                  if (WF)
                     flags_d = {sc_res == '0, sc_c, sc_res[WIDTH-1], sc_o};
               end
            end
         end
         ITER: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
               state_d = FIN;
         end
         FIN: begin
            alu_d   = acc_lo_q;
            hi_d    = acc_hi_q[WIDTH-1:0];
            done_d  = 1'b1;
            if (wf_q)
               flags_d = it_flags;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         wf_q     <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         alu_q    <= '0;
         hi_q     <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         wf_q     <= wf_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         alu_q    <= alu_d;
         hi_q     <= hi_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
      end
   end

   assign ALUOut   = alu_q;
   assign Hi       = hi_q;
   assign FlagsOut = flags_q;
   assign Busy     = (state_q != IDLE);
   assign Done     = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=16): hand-computed vectors per feature.
module tb_multicycle_alu;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic [3:0]  FunSel = '0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        WF = 1'b0;
   logic [15:0] ALUOut, Hi;
   logic [3:0]  FlagsOut;
   logic        Busy, Done;

   int errors = 0;
   int checks = 0;

   multicycle_alu #(.WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel),
      .A(A), .B(B), .WF(WF), .ALUOut(ALUOut), .Hi(Hi),
      .FlagsOut(FlagsOut), .Busy(Busy), .Done(Done)
   );

   always #5 Clock = ~Clock;

   // Drive one Start pulse; returns at the negedge right after the capture edge.
   task automatic issue(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                        input logic wf);
      @(negedge Clock);
      FunSel = fs; A = a; B = b; WF = wf; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   // Wait for Done (bounded), disturbing inputs and pulsing Start while Busy.
   task automatic wait_done(output int cyc, output int busy_n, output int overlap);
      cyc = 0; busy_n = 0; overlap = 0;
      while (Done !== 1'b1 && cyc < 40) begin
         if (Busy === 1'b1) busy_n++;
         if (cyc == 4) begin
            Start = 1'b1; FunSel = 4'b0010; A = 16'hAAAA; B = 16'h5555; WF = 1'b1;
         end else
            Start = 1'b0;
         @(negedge Clock);
         cyc++;
      end
      if (Busy === 1'b1 && Done === 1'b1) overlap = 1;
      Start = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge Clock);
      checks++;
      if ({ALUOut, Hi, FlagsOut, Busy, Done} !== '0) begin
         errors++;
         $display("FAIL reset_state got %h/%h/%b/%b/%b required all 0", ALUOut, Hi, FlagsOut, Busy, Done);
      end
      Reset = 1'b1;
   endtask

   task automatic test_add;
      issue(4'b0010, 16'hFFFF, 16'h0001, 1'b1);
      checks++;
      if (ALUOut !== 16'h0000 || Done !== 1'b1) begin
         errors++; $display("FAIL add_result got %h done=%b required 0000 done=1", ALUOut, Done);
      end
      checks++;
      if (FlagsOut !== 4'b1100) begin
         errors++; $display("FAIL add_flags got %b required 1100", FlagsOut);
      end
      @(negedge Clock);
      checks++;
      if (Done !== 1'b0 || ALUOut !== 16'h0000) begin
         errors++; $display("FAIL add_hold got done=%b res=%h required done=0 res=0000", Done, ALUOut);
      end
   endtask

   task automatic test_sub;
      issue(4'b0100, 16'h8000, 16'h0001, 1'b1);
      checks++;
      if (ALUOut !== 16'h7FFF || FlagsOut !== 4'b0001) begin
         errors++; $display("FAIL sub_ovf got %h %b required 7fff 0001", ALUOut, FlagsOut);
      end
      issue(4'b0100, 16'h0001, 16'h0002, 1'b0);
      checks++;
      if (ALUOut !== 16'hFFFF || FlagsOut !== 4'b0001) begin
         errors++; $display("FAIL sub_nowf got %h %b required ffff 0001", ALUOut, FlagsOut);
      end
   endtask

   task automatic test_mul;
      int cyc, busy_n, ov;
      issue(4'b1110, 16'h1234, 16'h0100, 1'b1);
      wait_done(cyc, busy_n, ov);
      checks++;
      if (cyc != 17 || busy_n != 17 || ov != 0) begin
         errors++; $display("FAIL mul_timing got done_cyc=%0d busy=%0d overlap=%0d required 17 17 0", cyc, busy_n, ov);
      end
      checks++;
      if ({Hi, ALUOut} !== 32'h0012_3400) begin
         errors++; $display("FAIL mul_result got %h required 00123400", {Hi, ALUOut});
      end
      checks++;
      if (FlagsOut !== 4'b0101) begin
         errors++; $display("FAIL mul_flags got %b required 0101", FlagsOut);
      end
      @(negedge Clock);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         errors++; $display("FAIL mul_after got done=%b busy=%b required 0 0", Done, Busy);
      end
   endtask

   task automatic test_divu;
      int cyc, busy_n, ov;
      issue(4'b1111, 16'd100, 16'd7, 1'b1);
      wait_done(cyc, busy_n, ov);
      checks++;
      if (cyc != 17 || ov != 0) begin
         errors++; $display("FAIL div_timing got done_cyc=%0d overlap=%0d required 17 0", cyc, ov);
      end
      checks++;
      if (ALUOut !== 16'd14 || Hi !== 16'd2 || FlagsOut !== 4'b0000) begin
         errors++; $display("FAIL div_result got q=%0d r=%0d f=%b required 14 2 0000", ALUOut, Hi, FlagsOut);
      end
   endtask

   task automatic test_div_zero;
      issue(4'b1111, 16'h0055, 16'h0000, 1'b1);
      checks++;
      if (Done !== 1'b1 || Busy !== 1'b0) begin
         errors++; $display("FAIL div0_timing got done=%b busy=%b required 1 0", Done, Busy);
      end
      checks++;
      if (ALUOut !== 16'hFFFF || Hi !== 16'h0055 || FlagsOut !== 4'b0011) begin
         errors++; $display("FAIL div0_result got %h %h %b required ffff 0055 0011", ALUOut, Hi, FlagsOut);
      end
   endtask

   task automatic test_rotate_adc;
      issue(4'b0010, 16'hFFFF, 16'h0001, 1'b1);
      issue(4'b1100, 16'h8001, 16'h0000, 1'b1);
      checks++;
      if (ALUOut !== 16'h0003 || FlagsOut !== 4'b0100 || Hi !== 16'h0000) begin
         errors++; $display("FAIL csl got %h %b hi=%h required 0003 0100 hi=0000", ALUOut, FlagsOut, Hi);
      end
      issue(4'b0011, 16'h0001, 16'h0001, 1'b1);
      checks++;
      if (ALUOut !== 16'h0003 || FlagsOut !== 4'b0000) begin
         errors++; $display("FAIL adc got %h %b required 0003 0000", ALUOut, FlagsOut);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge Clock);
      FunSel = 4'b0010; A = 16'h0001; B = 16'h0002; WF = 1'b1; Start = 1'b1;
      @(negedge Clock);
      checks++;
      if (ALUOut !== 16'h0003 || Done !== 1'b1) begin
         errors++; $display("FAIL b2b_first got %h done=%b required 0003 1", ALUOut, Done);
      end
      FunSel = 4'b0111; A = 16'hF0F0; B = 16'h0FF0;
      @(negedge Clock);
      Start = 1'b0;
      checks++;
      if (ALUOut !== 16'hFF00 || Done !== 1'b1 || FlagsOut !== 4'b0010) begin
         errors++; $display("FAIL b2b_second got %h done=%b f=%b required ff00 1 0010", ALUOut, Done, FlagsOut);
      end
      @(negedge Clock);
      checks++;
      if (ALUOut !== 16'hFF00 || Done !== 1'b0) begin
         errors++; $display("FAIL b2b_hold got %h done=%b required ff00 0", ALUOut, Done);
      end
   endtask

   task automatic test_reset_mid_mul;
      int done_seen, busy_seen;
      issue(4'b1110, 16'h1234, 16'h0100, 1'b1);
      repeat (5) @(negedge Clock);
      #2 Reset = 1'b0;
      #1;
      checks++;
      if ({ALUOut, Hi, FlagsOut, Busy, Done} !== '0) begin
         errors++; $display("FAIL reset_mid got %h/%h/%b/%b/%b required all 0", ALUOut, Hi, FlagsOut, Busy, Done);
      end
      @(negedge Clock);
      Reset = 1'b1;
      done_seen = 0; busy_seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge Clock);
         if (Done === 1'b1) done_seen++;
         if (Busy === 1'b1) busy_seen++;
      end
      checks++;
      if (done_seen != 0 || busy_seen != 0) begin
         errors++; $display("FAIL reset_abort got done=%0d busy=%0d required 0 0", done_seen, busy_seen);
      end
      issue(4'b0010, 16'h0002, 16'h0003, 1'b1);
      checks++;
      if (ALUOut !== 16'h0005 || Done !== 1'b1 || FlagsOut !== 4'b0000) begin
         errors++; $display("FAIL reset_add got %h done=%b f=%b required 0005 1 0000", ALUOut, Done, FlagsOut);
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_mul;
      test_divu;
      test_div_zero;
      test_rotate_adc;
      test_back_to_back;
      test_reset_mid_mul;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
